mux_arb_4bit_2ch: RTL
=====================

MUX_ARB_4BIT_2CH -- requirements
Module: mux_arb_4bit_2ch

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive beats granted to one channel while the other channel requests; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_a  input  1  channel A requests the shared 4-bit path.
REQ-005 a  input  4  channel A data.
REQ-006 req_b  input  1  channel B requests the shared 4-bit path.
REQ-007 b  input  4  channel B data.
REQ-008 gnt_a  output  1  channel A owns the path this cycle.
REQ-009 gnt_b  output  1  channel B owns the path this cycle.
REQ-010 s  output  1  current mux select: 0 = a, 1 = b.
REQ-011 y  output  4  registered selected data.
REQ-012 y_valid  output  1  y holds a transferred beat.

Function
REQ-013 States SHALL be IDLE, GNT_A, GNT_B; gnt_a = (state==GNT_A), gnt_b = (state==GNT_B), decoded from the state register only (Moore).
REQ-014 s SHALL be 1 in GNT_B, 0 in GNT_A, and hold its last value in IDLE.
REQ-015 Beat: a cycle with (gnt_a && req_a) or (gnt_b && req_b); on a beat edge y <= selected data (a if s=0, b if s=1) and y_valid <= 1; otherwise y holds and y_valid <= 0.
REQ-016 Latency: request high at edge N while IDLE -> grant visible cycle N+1; first beat's data on y with y_valid=1 in cycle N+2.
REQ-017 IDLE: only req_a -> GNT_A; only req_b -> GNT_B; both -> channel not recorded in last-served register; neither -> stay.
REQ-018 last-served register SHALL update to A/B on every entry into GNT_A/GNT_B.
REQ-019 Hold counter (4 bits) SHALL clear on entry to any grant state and increment on each beat; no wrap, saturates at 15.
REQ-020 In GNT_x: owner's req low -> go to other grant if other req high, else IDLE (no dead cycle when switching).
REQ-021 In GNT_x: owner's req high, beat makes count reach MAX_HOLD, other req high -> switch to other grant next cycle.
REQ-022 In GNT_x: owner's req high, other req low -> stay regardless of count (counter saturates).
REQ-023 gnt_a and gnt_b SHALL never both be 1; a grant SHALL never be issued to a channel whose req was low at the deciding edge.
REQ-024 Data inputs a/b are sampled only on beats; changes outside beats SHALL not affect y.
REQ-025 Requesters MAY drop req at any time; the beat in the cycle req is low is not taken.

Reset
REQ-026 rst high at an edge SHALL force: state=IDLE, gnt_a=0, gnt_b=0, s=0, y=4'h0, y_valid=0, hold counter=0, last-served=B (so A wins first tie).
REQ-027 Reset mid-grant SHALL abort the grant with no further beat; rst overrides all other inputs in the same edge.
REQ-028 First decision after reset release SHALL occur at the first edge with rst low.

Verification
REQ-029 Reset then req_a=1,a=4'h5 from edge 1 -> gnt_a=1 cycle 2, y=4'h5,y_valid=1 cycle 3, gnt_b=0 throughout.
REQ-030 After reset, req_a=req_b=1 same edge, a=4'h3,b=4'hC, MAX_HOLD=4 -> 4 beats of 4'h3, then 4 beats of 4'hC, alternating; s toggles with no IDLE gap.
REQ-031 GNT_A with only req_a held 20 cycles -> gnt_a stays 1, counter saturates at 15, 20 consecutive y_valid beats.
REQ-032 GNT_A, req_a drops while req_b=1, b=4'h9 -> gnt_b next cycle, y=4'h9 the cycle after, no y_valid during dropped-req cycle.
REQ-033 rst asserted during GNT_B beat -> next cycle all outputs at reset values; subsequent tie grants A first.
REQ-034 Random req/data 10k cycles with scoreboard -> never both grants, every y_valid beat matches owner data, no channel starved beyond MAX_HOLD beats of the other.

Source files
------------

// File: rtl/mux_arb_4bit_2ch.sv
// Two-channel round-robin arbiter feeding a registered 4-bit mux; grant one cycle after request, data one after that.
// No backpressure on y: a requester is stalled only by not holding grant, and may drop req at any cycle.
module mux_arb_4bit_2ch #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [3:0] a,
  input  logic       req_b,
  input  logic [3:0] b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       s,
  output logic [3:0] y,
  output logic       y_valid
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t     state, state_nxt;
  logic       last_b;
  logic [3:0] hold_cnt;
  logic       s_q;
  logic       beat;
  logic [4:0] cnt_inc;
  logic       at_limit;
  logic       enter;

  assign gnt_a = (state == GNT_A);
  assign gnt_b = (state == GNT_B);
  assign s     = s_q;

  always_comb begin
    beat      = (gnt_a && req_a) || (gnt_b && req_b);
    cnt_inc   = {1'b0, hold_cnt} + 5'd1;
    // Compare against >= so a count already saturated past the limit still yields.
    at_limit  = (cnt_inc >= 5'(MAX_HOLD));
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_a && req_b) state_nxt = last_b ? GNT_A : GNT_B;
        else if (req_a)     state_nxt = GNT_A;
        else if (req_b)     state_nxt = GNT_B;
      end
      GNT_A: begin
        if (!req_a)                 state_nxt = req_b ? GNT_B : IDLE;
        else if (req_b && at_limit) state_nxt = GNT_B;
      end
      GNT_B: begin
        if (!req_b)                 state_nxt = req_a ? GNT_A : IDLE;
        else if (req_a && at_limit) state_nxt = GNT_A;
      end
      default: state_nxt = IDLE;
    endcase
    enter = (state_nxt != state) && (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s_q      <= 1'b0;
      y        <= 4'h0;
      y_valid  <= 1'b0;
      hold_cnt <= 4'h0;
      last_b   <= 1'b1;
    end else begin
      state <= state_nxt;
      if (enter) begin
        hold_cnt <= 4'h0;
        last_b   <= (state_nxt == GNT_B);
      end else if (beat && hold_cnt != 4'hF) begin
        hold_cnt <= hold_cnt + 4'h1;
      end
      // Select tracks the owner and keeps its value while idle.
      if (state_nxt == GNT_A)      s_q <= 1'b0;
      else if (state_nxt == GNT_B) s_q <= 1'b1;
      y_valid <= beat;
      if (beat) y <= s_q ? b : a;
    end
  end

endmodule
